// File: rtl/hazard_scoreboard_if.sv
// ID/EX/WB hazard-unit signal bundle.
// master = pipeline side (drives decode info), slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LAT_W    = 4,
  parameter int CNT_W    = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rs3;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_use_rs3;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_long;
  logic [LAT_W-1:0]  id_lat;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              br_ctrl;

  logic              load_stall;
  logic              sb_stall;
  logic              stall;
  logic              flush;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs3, id_use_rs1, id_use_rs2, id_use_rs3,
           id_rd, id_rd_we, id_long, id_lat, ex_mem_read, ex_rd, wb_valid, wb_rd, br_ctrl,
    input  load_stall, sb_stall, stall, flush, busy_vec, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs3, id_use_rs1, id_use_rs2, id_use_rs3,
           id_rd, id_rd_we, id_long, id_lat, ex_mem_read, ex_rd, wb_valid, wb_rd, br_ctrl,
    output load_stall, sb_stall, stall, flush, busy_vec, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard unit: load-use detection, per-register long-latency scoreboard,
// multi-cycle branch flush and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int LAT_W        = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rstn,
  hazard_scoreboard_if.slave hz
);
  localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int EXT_SZ = 1 << REG_AW;

  logic [NUM_REGS-1:0] busy_q;
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [FC_W-1:0]     fcnt_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [EXT_SZ-1:0]   busy_ext;

  logic hit1, hit2, hit3;
  logic load_stall, sb_stall, stall, flush, issue;

  // Indices above NUM_REGS-1 read as never busy.
  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_q;
  end

  assign hit1 = hz.id_use_rs1 & (hz.id_rs1 != '0);
  assign hit2 = hz.id_use_rs2 & (hz.id_rs2 != '0);
  assign hit3 = hz.id_use_rs3 & (hz.id_rs3 != '0);

  assign load_stall = rstn & hz.id_valid & hz.ex_mem_read & (hz.ex_rd != '0) &
                      ((hit1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hit2 & (hz.id_rs2 == hz.ex_rd)) |
                       (hit3 & (hz.id_rs3 == hz.ex_rd)));

  assign sb_stall = hz.id_valid &
                    ((hit1 & busy_ext[hz.id_rs1]) |
                     (hit2 & busy_ext[hz.id_rs2]) |
                     (hit3 & busy_ext[hz.id_rs3]) |
                     (hz.id_rd_we & (hz.id_rd != '0) & busy_ext[hz.id_rd]));

  // id_valid qualifies the ID slot and stall acts as the inverse of ready:
  // the ID instruction moves into EX only in a cycle with id_valid & ~stall & ~flush.
  assign flush = hz.br_ctrl | (fcnt_q != '0);
  assign stall = (load_stall | sb_stall) & ~flush;
  assign issue = hz.id_valid & hz.id_long & hz.id_rd_we & (hz.id_rd != '0) & ~stall & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      // Slot 0 is never written, so x0 stays permanently idle.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (issue && (hz.id_rd == REG_AW'(i))) begin
          busy_q[i] <= 1'b1;
          cnt_q[i]  <= hz.id_lat;
        end else if (hz.wb_valid && (hz.wb_rd == REG_AW'(i))) begin
          busy_q[i] <= 1'b0;
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] == LAT_W'(1)) begin
          busy_q[i] <= 1'b0;
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] > LAT_W'(1)) begin
          cnt_q[i]  <= cnt_q[i] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fcnt_q <= '0;
    end else if (hz.br_ctrl) begin
      fcnt_q <= FC_W'(FLUSH_CYCLES - 1);
    end else if (fcnt_q != '0) begin
      fcnt_q <= fcnt_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.load_stall = load_stall;
  assign hz.sb_stall   = sb_stall;
  assign hz.stall      = stall;
  assign hz.flush      = flush;
  assign hz.busy_vec   = busy_q;
  assign hz.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with FLUSH_CYCLES=3 and CNT_W=4.
module tb_hazard_scoreboard;
  localparam int NUM_REGS     = 32;
  localparam int REG_AW       = 5;
  localparam int LAT_W        = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 4;

  logic clk;
  logic rstn;

  hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) hz ();

  hazard_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rs3 = 0;
    hz.id_use_rs1 = 0; hz.id_use_rs2 = 0; hz.id_use_rs3 = 0;
    hz.id_rd = 0; hz.id_rd_we = 0; hz.id_long = 0; hz.id_lat = 0;
    hz.ex_mem_read = 0; hz.ex_rd = 0; hz.wb_valid = 0; hz.wb_rd = 0; hz.br_ctrl = 0;
  endtask

  task automatic issue_long(input logic [REG_AW-1:0] rd, input logic [LAT_W-1:0] lat);
    idle();
    hz.id_valid = 1; hz.id_long = 1; hz.id_rd_we = 1; hz.id_rd = rd; hz.id_lat = lat;
  endtask

  initial begin
    // reset state, with a load-use pattern and br_ctrl present
    rstn = 0;
    idle();
    hz.id_valid = 1; hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
    hz.br_ctrl = 1;
    #2;
    check("rst_busy", hz.busy_vec, 0);
    check("rst_cnt", hz.stall_cnt, 0);
    check("rst_load_stall", hz.load_stall, 0);
    check("rst_stall", hz.stall, 0);
    check("rst_flush", hz.flush, 1);
    idle();
    @(posedge clk);
    #2 rstn = 1;
    tick();

    // load-use
    hz.id_valid = 1; hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs2 = 5; hz.id_use_rs2 = 1;
    #1;
    check("lu_load_stall", hz.load_stall, 1);
    check("lu_stall", hz.stall, 1);
    check("lu_sb_stall", hz.sb_stall, 0);
    hz.id_use_rs2 = 0; #1;
    check("lu_unused_src", hz.load_stall, 0);
    hz.id_use_rs2 = 1; hz.ex_rd = 0; #1;
    check("lu_ex_rd_x0", hz.load_stall, 0);
    hz.ex_rd = 5; hz.id_use_rs2 = 0; hz.id_rs3 = 5; hz.id_use_rs3 = 1; #1;
    check("lu_rs3", hz.load_stall, 1);
    idle();
    tick();
    check("lu_no_count", hz.stall_cnt, 0);

    // fixed latency 3 on x7 with a dependent reader held in ID
    issue_long(7, 3);
    #1;
    check("fx_issue_stall", hz.stall, 0);
    tick();
    idle();
    hz.id_valid = 1; hz.id_rs1 = 7; hz.id_use_rs1 = 1;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      #1;
      check("fx_busy7", hz.busy_vec[7], e);
      check("fx_stall", hz.stall, e);
      tick();
    end
    check("fx_stall_cnt", hz.stall_cnt, 3);
    idle();

    // variable latency on x9 with a WAW follower
    issue_long(9, 0);
    tick();
    idle();
    hz.id_valid = 1; hz.id_rd_we = 1; hz.id_rd = 9;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("var_waw_stall", hz.sb_stall, 1);
      tick();
    end
    hz.wb_valid = 1; hz.wb_rd = 3;
    tick();
    hz.wb_valid = 0; #1;
    check("var_wb_idle_reg", hz.busy_vec, 32'h200);
    check("var_still_stall", hz.stall, 1);
    hz.wb_valid = 1; hz.wb_rd = 9; #1;
    check("var_wb_same_cycle", hz.stall, 1);
    tick();
    hz.wb_valid = 0; #1;
    check("var_wb_released", hz.stall, 0);
    check("var_busy_clear", hz.busy_vec, 0);
    check("var_stall_cnt", hz.stall_cnt, 10);
    idle();

    // issue beats a same-cycle writeback to the same register
    issue_long(4, 2);
    hz.wb_valid = 1; hz.wb_rd = 4;
    tick();
    idle(); #1;
    check("pri_issue_wins", hz.busy_vec, 32'h10);
    tick();
    check("pri_cnt2", hz.busy_vec, 32'h10);
    tick();
    check("pri_clear", hz.busy_vec, 0);
    issue_long(0, 3);
    tick();
    idle(); #1;
    check("pri_x0_issue", hz.busy_vec, 0);
    // writeback cuts a fixed countdown short
    issue_long(6, 5);
    tick();
    idle();
    hz.wb_valid = 1; hz.wb_rd = 6; #1;
    check("pri_x6_busy", hz.busy_vec, 32'h40);
    tick();
    hz.wb_valid = 0; #1;
    check("pri_wb_early", hz.busy_vec, 0);

    // flush over a live scoreboard hazard
    issue_long(10, 6);
    tick();
    idle();
    hz.id_valid = 1; hz.id_rs1 = 10; hz.id_use_rs1 = 1;
    hz.id_long = 1; hz.id_rd_we = 1; hz.id_rd = 11; hz.id_lat = 2;
    #1;
    check("fl_pre_stall", hz.stall, 1);
    hz.br_ctrl = 1; #1;
    check("fl_c0_flush", hz.flush, 1);
    check("fl_c0_stall", hz.stall, 0);
    tick();
    hz.br_ctrl = 0; #1;
    check("fl_c1_flush", hz.flush, 1);
    check("fl_c1_stall", hz.stall, 0);
    check("fl_no_issue", hz.busy_vec, 32'h400);
    tick();
    check("fl_c2_flush", hz.flush, 1);
    tick();
    check("fl_c3_flush", hz.flush, 0);
    check("fl_c3_stall", hz.stall, 1);
    check("fl_c3_busy", hz.busy_vec, 32'h400);
    idle();
    tick();
    check("fl_t5_busy", hz.busy_vec, 32'h400);
    tick();
    check("fl_t6_busy", hz.busy_vec, 32'h400);
    tick();
    check("fl_t7_clear", hz.busy_vec, 0);
    check("fl_stall_cnt", hz.stall_cnt, 10);

    // second br_ctrl during the hold reloads the flush counter
    hz.br_ctrl = 1; #1;
    check("rl_c0", hz.flush, 1);
    tick();
    hz.br_ctrl = 0; #1;
    check("rl_c1", hz.flush, 1);
    tick();
    hz.br_ctrl = 1; #1;
    check("rl_c2", hz.flush, 1);
    tick();
    hz.br_ctrl = 0; #1;
    check("rl_c3", hz.flush, 1);
    tick();
    check("rl_c4", hz.flush, 1);
    tick();
    check("rl_c5", hz.flush, 0);

    // stall counter saturation
    hz.id_valid = 1; hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
    for (int i = 0; i < 3; i++) tick();
    check("sat_count", hz.stall_cnt, 13);
    for (int i = 0; i < 17; i++) tick();
    check("sat_hold", hz.stall_cnt, 15);
    idle();

    // asynchronous reset mid-countdown
    issue_long(12, 8);
    tick();
    issue_long(13, 0);
    tick();
    idle(); #1;
    check("ar_busy_pre", hz.busy_vec, 32'h3000);
    #1 rstn = 0;
    #1;
    check("ar_busy", hz.busy_vec, 0);
    check("ar_cnt", hz.stall_cnt, 0);
    @(posedge clk);
    #2 rstn = 1;
    tick();
    check("ar_no_resume", hz.busy_vec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the AdamRiscv pipeline, sitting between ID and EX. It combines load-use detection with a per-register scoreboard that tracks long-latency writers, such as M-type matrix ops and variable-latency memory ops. Outputs are a unified stall and a multi-cycle branch flush. A saturating counter reports stall cycles for performance monitoring.

## Interface
- NUM_REGS, 32, number of architectural registers tracked (x0 never tracked)
- REG_AW, 5, register index width; NUM_REGS <= 2**REG_AW
- LAT_W, 4, latency field width; fixed latencies 1..2**LAT_W-1
- FLUSH_CYCLES, 1, cycles flush stays asserted per br_ctrl pulse (>=1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2, id_rs3  in  REG_AW each  source indices (rs3 = accumulator source of M-type)
- id_use_rs1, id_use_rs2, id_use_rs3  in  1 each  corresponding source is actually read
- id_rd  in  REG_AW  destination index
- id_rd_we  in  1  instruction writes id_rd
- id_long  in  1  instruction is a long-latency writer
- id_lat  in  LAT_W  fixed latency; 0 = variable, cleared only by writeback
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_AW  EX destination
- wb_valid  in  1  long-latency result written back this cycle
- wb_rd  in  REG_AW  register written back
- br_ctrl  in  1  branch/jump redirect taken
- load_stall  out  1  load-use hazard
- sb_stall  out  1  scoreboard hazard (RAW or WAW on busy register)
- stall  out  1  freeze PC/IF/ID, bubble into EX
- flush  out  1  kill IF/ID contents
- busy_vec  out  NUM_REGS  registered busy bits, bit i = register i
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1

## Operation
- Source hit (per source k): id_use_rsk & rsk != 0.
- load_stall = id_valid & ex_mem_read & ex_rd != 0 & any source hit with rsk == ex_rd.
- sb_stall = id_valid & (any source hit with busy[rsk], or id_rd_we & id_rd != 0 & busy[id_rd]).
- Registered state is busy[i] plus cnt[i] (LAT_W bits) for every i in 1..NUM_REGS-1. busy[0] and cnt[0] are constant 0.
- The hazard decode reads only the registered busy bits. A clear in cycle t is not visible to the decode until t+1.
- flush = br_ctrl | (fcnt != 0). fcnt is loaded with FLUSH_CYCLES-1 on br_ctrl and decrements to 0 otherwise. A new br_ctrl during the hold reloads fcnt.
- stall = (load_stall | sb_stall) & ~flush. Flush has priority.
- issue = id_valid & id_long & id_rd_we & id_rd != 0 & ~stall & ~flush.
- On issue: busy[id_rd] <= 1 and cnt[id_rd] <= id_lat.
- Per-register update priority, highest first:
  - issue to that register;
  - wb_valid & wb_rd == i, which clears busy and cnt;
  - cnt == 1, which clears busy;
  - cnt > 1, which decrements cnt.
- When cnt == 0 and busy == 1 (variable latency), only writeback clears the register.
- A writeback to a non-busy register, or to x0, is ignored.
- Flush does not clear the scoreboard. Older in-flight ops still complete.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset (rstn low, asynchronous) values:
  - busy_vec = 0, all cnt = 0, fcnt = 0, stall_cnt = 0;
  - load_stall, sb_stall, stall = 0;
  - flush = br_ctrl.
- The combinational outputs load_stall, sb_stall, stall and flush are valid in the same cycle as their inputs.
- busy_vec, stall_cnt and fcnt update on the clk rising edge.
- Fixed-latency issue at edge t with id_lat = L: busy is visible in cycles t+1 … t+L and clear from t+L+1. A dependent instruction held in ID stalls for exactly L cycles.
- Variable-latency issue: busy from t+1 until the cycle after the wb_valid edge.
- Flush: a single-cycle br_ctrl gives flush high for exactly FLUSH_CYCLES cycles, starting in the br_ctrl cycle.
- Reset asserted mid-operation clears all pending busy bits immediately. There is no resumption.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, id_valid=1 -> load_stall=1 and stall=1 in the same cycle. Repeating with id_use_rs2=0, or with ex_rd=0, gives 0.
- Fixed latency: issue id_rd=7, id_lat=3. Then hold an instruction reading x7 -> busy_vec[7]=1 for 3 cycles, stall=1 for 3 cycles, stall_cnt=3, busy_vec[7]=0 on the 4th cycle.
- Variable latency plus WAW: issue id_rd=9, id_lat=0. A later instruction writing x9 stalls indefinitely. Pulse wb_valid with wb_rd=9 -> stall drops the next cycle. A writeback to x3 (not busy) changes nothing.
- Simultaneous events: in one cycle, issue to x4 (id_lat=2) while wb_rd=4 and x4's cnt reaches 1 -> busy_vec[4]=1 with cnt=2 afterwards (issue wins). Issue with id_rd=0 -> busy_vec stays 0.
- Flush: with FLUSH_CYCLES=3, pulse br_ctrl for 1 cycle -> flush high for 3 cycles. While a scoreboard hazard is present, stall=0 and no issue occurs during the flush, and existing busy bits keep counting down. A second br_ctrl in hold cycle 2 extends flush to 3 more cycles.
- Reset and saturation: with CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15. Assert rstn=0 mid-countdown -> busy_vec=0 and stall_cnt=0 immediately, without waiting for a clock edge.
